// File: rtl/reg_read_port.sv
// reg_read_port: read side of the 16-bit register bank.
// It holds NREGS registers that are written through a load-style port.
// Read requests arrive on a valid/ready handshake. Each response is
// captured into a 2-entry buffer and returned in request order. All
// state updates on the falling edge of clk. rst_n is an asynchronous,
// active-low reset.
//
// Ports
//   clk        clock (falling edge active)
//   rst_n      async active-low reset
//   wr_en      write strobe, reg[wr_addr] <= wr_data
//   wr_addr    write address
//   wr_data    write data
//   req_valid  read request present
//   req_ready  request can be accepted (registered)
//   req_addr   register to read, sampled on accept
//   rsp_valid  rsp_data/rsp_addr hold a valid response (registered)
//   rsp_ready  consumer takes the response
//   rsp_data   oldest buffered read data
//   rsp_addr   address that produced rsp_data
module reg_read_port #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [AW-1:0]    rsp_addr
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_regs [NREGS];

  // Head entry drives the outputs. The tail entry is used only when FULL.
  logic [WIDTH-1:0] r_head_data;
  logic [AW-1:0]    r_head_addr;
  logic [WIDTH-1:0] r_tail_data;
  logic [AW-1:0]    r_tail_addr;
  logic             r_req_ready;
  logic             r_rsp_valid;

  logic             w_accept;
  logic             w_drain;
  logic             w_ld_head;
  logic             w_ld_tail;
  logic             w_shift;
  logic [WIDTH-1:0] w_rd_data;

  assign w_accept = req_valid & r_req_ready;
  assign w_drain  = r_rsp_valid & rsp_ready;

  // A write and a read of the same address on the same edge return the
  // new data (write-first bypass).
  assign w_rd_data = (wr_en && (wr_addr == req_addr)) ? wr_data : r_regs[req_addr];

  always_comb begin
    w_state_nxt = r_state;
    w_ld_head   = 1'b0;
    w_ld_tail   = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = S_ONE;
          w_ld_head   = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && !w_drain) begin
          w_state_nxt = S_FULL;
          w_ld_tail   = 1'b1;
        end else if (w_drain && !w_accept) begin
          w_state_nxt = S_EMPTY;
        end else if (w_accept && w_drain) begin
          // The head leaves and the new response takes its place.
          w_ld_head   = 1'b1;
        end
      end
      S_FULL: begin
        // req_ready is low here, so only a drain can occur.
        if (w_drain) begin
          w_state_nxt = S_ONE;
          w_shift     = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt != S_FULL);
      r_rsp_valid <= (w_state_nxt != S_EMPTY);
    end
  end

  // The head holds its last value when the buffer empties.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_data <= '0;
      r_head_addr <= '0;
      r_tail_data <= '0;
      r_tail_addr <= '0;
    end else begin
      if (w_ld_head) begin
        r_head_data <= w_rd_data;
        r_head_addr <= req_addr;
      end else if (w_shift) begin
        r_head_data <= r_tail_data;
        r_head_addr <= r_tail_addr;
      end
      if (w_ld_tail) begin
        r_tail_data <= w_rd_data;
        r_tail_addr <= req_addr;
      end
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wr_en) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_head_data;
  assign rsp_addr  = r_head_addr;

endmodule
